// File: rtl/lcrc_tx_sequencer.sv
// -----------------------------------------------------------------------------
// lcrc_tx_sequencer
//   Data-link TX framer that sequences an external lcrc_32 engine per TLP.
//   The frame for each TLP is: 2-byte sequence header, N payload bytes, 4 LCRC bytes.
//   The engine is cleared at the start of every TLP. It absorbs the header and
//   payload bytes, and its registered result is captured once before the LCRC
//   bytes are emitted LSB first.
//
//   Optional feature (macro LCRC_NULLIFY_EN):
//     Adds input in_nullify, sampled with the accepted in_eop byte. A nullified
//     TLP is sent with inverted LCRC bytes and does not consume a sequence number.
//
// Ports
//   clk, reset         clock; asynchronous active-low reset
//   in_data/in_valid/in_eop/in_ready   payload byte stream (valid/ready)
//   in_nullify         (LCRC_NULLIFY_EN only) nullify the current TLP
//   rb_full            replay buffer full; only gates the start of a TLP
//   crc_clr/crc_en/crc_din             engine control
//   crc_result         engine's registered CRC
//   out_data/out_valid/out_sop/out_eop/out_ready  framed byte stream
//   seq_num            sequence number of the next TLP to be framed
//   len_err            sticky payload-overlength flag
// -----------------------------------------------------------------------------
module lcrc_tx_sequencer #(
    parameter int          WIDTH     = 8,
    parameter logic [11:0] SEQ_INIT  = 12'h000,
    parameter int          MAX_BYTES = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_eop,
`ifdef LCRC_NULLIFY_EN
    input  logic             in_nullify,
`endif
    output logic             in_ready,
    input  logic             rb_full,
    output logic             crc_clr,
    output logic             crc_en,
    output logic [WIDTH-1:0] crc_din,
    input  logic [31:0]      crc_result,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    input  logic             out_ready,
    output logic [11:0]      seq_num,
    output logic             len_err
);

    // Counter saturates at MAX_BYTES+1, so it needs room for that value.
    localparam int               CNT_W   = $clog2(MAX_BYTES + 2);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    typedef enum logic [3:0] {
        IDLE, SEQ_HI, SEQ_LO, DATA, CRC_WAIT, CRC0, CRC1, CRC2, CRC3
    } state_t;

    state_t           state, state_d;
    logic             adv;
    logic             load;
    logic [WIDTH-1:0] ld_data;
    logic             ld_sop, ld_eop;
    logic             accept;
    logic [31:0]      crc_hold;
    logic [CNT_W-1:0] byte_cnt;
    logic             nullify_q;
    logic [WIDTH-1:0] crc_mask;

    // The output register advances when empty or when its byte is taken.
    assign adv      = !out_valid || out_ready;
    assign crc_mask = {WIDTH{nullify_q}};

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d  = state;
        crc_clr  = 1'b0;
        crc_en   = 1'b0;
        crc_din  = '0;
        in_ready = 1'b0;
        load     = 1'b0;
        ld_data  = '0;
        ld_sop   = 1'b0;
        ld_eop   = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                // The reset term keeps crc_clr low while reset is held and
                // in_valid happens to be high.
                if (reset && !rb_full && in_valid) begin
                    crc_clr = 1'b1;
                    state_d = SEQ_HI;
                end
            end
            SEQ_HI: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = {4'h0, seq_num[11:8]};
                    ld_sop  = 1'b1;
                    crc_en  = 1'b1;
                    crc_din = ld_data;
                    state_d = SEQ_LO;
                end
            end
            SEQ_LO: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = seq_num[7:0];
                    crc_en  = 1'b1;
                    crc_din = ld_data;
                    state_d = DATA;
                end
            end
            DATA: begin
                in_ready = adv;
                if (in_valid && adv) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    ld_data = in_data;
                    crc_en  = 1'b1;
                    crc_din = in_data;
                    if (in_eop) state_d = CRC_WAIT;
                end
            end
            // The engine result for the last byte appears in this cycle.
            CRC_WAIT: state_d = CRC0;
            CRC0: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = crc_hold[7:0] ^ crc_mask;
                    state_d = CRC1;
                end
            end
            CRC1: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = crc_hold[15:8] ^ crc_mask;
                    state_d = CRC2;
                end
            end
            CRC2: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = crc_hold[23:16] ^ crc_mask;
                    state_d = CRC3;
                end
            end
            CRC3: begin
                if (adv) begin
                    load    = 1'b1;
                    ld_data = crc_hold[31:24] ^ crc_mask;
                    ld_eop  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------ output register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
        end else if (adv) begin
            out_valid <= load;
            out_data  <= ld_data;
            out_sop   <= ld_sop;
            out_eop   <= ld_eop;
        end
    end

    // ------------------------------------------------- CRC capture, seq num
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_hold <= '0;
            seq_num  <= SEQ_INIT;
        end else begin
            if (state == CRC_WAIT) crc_hold <= crc_result;
            // A nullified TLP does not consume a sequence number.
            if (state == CRC3 && adv && !nullify_q) seq_num <= seq_num + 12'd1;
        end
    end

    // ------------------------------------------------ payload length check
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            len_err  <= 1'b0;
        end else if (crc_clr) begin
            byte_cnt <= '0;
        end else if (accept) begin
            if (byte_cnt >= MAX_CNT) len_err  <= 1'b1;
            if (byte_cnt <= MAX_CNT) byte_cnt <= byte_cnt + 1'b1;
        end
    end

`ifdef LCRC_NULLIFY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 nullify_q <= 1'b0;
        else if (accept && in_eop)  nullify_q <= in_nullify;
    end
`else
    assign nullify_q = 1'b0;
`endif

endmodule

// File: tb/tb_lcrc_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lcrc_tx_sequencer
//   Directed bench for lcrc_tx_sequencer. Two instances share the same stimulus:
//   u_dut uses SEQ_INIT=0 and MAX_BYTES=4, and u_wrap uses SEQ_INIT=12'hFFE.
//   Each instance has its own behavioural lcrc_32 engine (reflected CRC-32,
//   polynomial 0xEDB88320, cleared to all ones, no final xor).
//   Expected frames are rebuilt from the payload and the expected sequence number.
// -----------------------------------------------------------------------------
module tb_lcrc_tx_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_eop = 1'b0;
`ifdef LCRC_NULLIFY_EN
    logic        in_nullify = 1'b0;
`endif
    logic        rb_full = 1'b0;
    logic        out_ready = 1'b1;
    logic [1:0]  in_ready, crc_clr, crc_en, out_valid, out_sop, out_eop, len_err;
    logic [7:0]  crc_din [2];
    logic [7:0]  out_data [2];
    logic [11:0] seq_num [2];
    logic [31:0] eng [2] = '{32'h0, 32'h0};

    int          n_cmp = 0, n_err = 0;
    int          rdy_mode = 0;
    logic [9:0]  q0[$], q1[$];
    int          eop_cnt [2] = '{0, 0};
    int          en_cnt [2] = '{0, 0};
    int          stall_err [2] = '{0, 0};
    logic        stall_v [2] = '{1'b0, 1'b0};
    logic [7:0]  stall_d [2];
    logic [11:0] exp_seq [2] = '{12'h000, 12'hFFE};
    logic [7:0]  pl[$];

    always #5 clk = ~clk;

    lcrc_tx_sequencer #(.WIDTH(8), .SEQ_INIT(12'h000), .MAX_BYTES(4)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_eop(in_eop),
`ifdef LCRC_NULLIFY_EN
        .in_nullify(in_nullify),
`endif
        .in_ready(in_ready[0]), .rb_full(rb_full), .crc_clr(crc_clr[0]), .crc_en(crc_en[0]),
        .crc_din(crc_din[0]), .crc_result(eng[0]), .out_data(out_data[0]),
        .out_valid(out_valid[0]), .out_sop(out_sop[0]), .out_eop(out_eop[0]),
        .out_ready(out_ready), .seq_num(seq_num[0]), .len_err(len_err[0])
    );

    lcrc_tx_sequencer #(.WIDTH(8), .SEQ_INIT(12'hFFE), .MAX_BYTES(4096)) u_wrap (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_eop(in_eop),
`ifdef LCRC_NULLIFY_EN
        .in_nullify(in_nullify),
`endif
        .in_ready(in_ready[1]), .rb_full(rb_full), .crc_clr(crc_clr[1]), .crc_en(crc_en[1]),
        .crc_din(crc_din[1]), .crc_result(eng[1]), .out_data(out_data[1]),
        .out_valid(out_valid[1]), .out_sop(out_sop[1]), .out_eop(out_eop[1]),
        .out_ready(out_ready), .seq_num(seq_num[1]), .len_err(len_err[1])
    );

    function automatic logic [31:0] crc_upd(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return c;
    endfunction

    // Behavioural lcrc_32 engines.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (crc_clr[i])     eng[i] <= 32'hFFFF_FFFF;
            else if (crc_en[i]) eng[i] <= crc_upd(eng[i], crc_din[i]);
        end
    end

    // out_ready: mode 0 always ready, mode 1 toggles every cycle.
    always @(posedge clk) begin
        #1;
        out_ready = (rdy_mode == 1) ? ~out_ready : 1'b1;
    end

    // Monitor: a byte seen valid & ready at the negedge is taken at the next posedge.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (out_valid[i] && out_ready) begin
                    if (i == 0) q0.push_back({out_sop[i], out_eop[i], out_data[i]});
                    else        q1.push_back({out_sop[i], out_eop[i], out_data[i]});
                    if (out_eop[i]) eop_cnt[i]++;
                end
                if (crc_en[i]) en_cnt[i]++;
                if (stall_v[i] && !(out_valid[i] && out_data[i] == stall_d[i])) stall_err[i]++;
                stall_v[i] = out_valid[i] && !out_ready;
                stall_d[i] = out_data[i];
            end
        end else begin
            stall_v[0] = 1'b0;
            stall_v[1] = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [9:0] pop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Drive the first cnt bytes of pl; in_eop marks the last byte of pl.
    task automatic send(input int cnt, input logic nul);
        for (int k = 0; k < cnt; k++) begin
            int w = 0;
            in_valid = 1'b1;
            in_data  = pl[k];
            in_eop   = (k == pl.size() - 1);
`ifdef LCRC_NULLIFY_EN
            in_nullify = nul;
`endif
            forever begin
                @(negedge clk);
                if (in_ready[0]) begin
                    @(posedge clk); #1;
                    break;
                end
                if (++w > 500) begin
                    chk("send_timeout", 32'(w), 32'd0);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_eop   = 1'b0;
`ifdef LCRC_NULLIFY_EN
        in_nullify = 1'b0;
`endif
        if (nul) begin end
    endtask

    // Wait for one full frame on both instances, then compare it with the model.
    task automatic frames(input logic nul);
        int m = pl.size() + 6;
        for (int c = 0; c < 600 && !(q0.size() >= m && q1.size() >= m); c++) @(negedge clk);
        chk("frame_wait", 32'(q0.size() >= m && q1.size() >= m), 32'd1);
        for (int i = 0; i < 2; i++) begin
            logic [7:0]  ex[$];
            logic [31:0] crc = 32'hFFFF_FFFF;
            ex.push_back({4'h0, exp_seq[i][11:8]});
            ex.push_back(exp_seq[i][7:0]);
            foreach (pl[k]) ex.push_back(pl[k]);
            foreach (ex[k]) crc = crc_upd(crc, ex[k]);
            if (nul) crc = ~crc;
            ex.push_back(crc[7:0]);   ex.push_back(crc[15:8]);
            ex.push_back(crc[23:16]); ex.push_back(crc[31:24]);
            for (int k = 0; k < m; k++) begin
                logic [9:0] got = ((i == 0) ? q0.size() : q1.size()) > 0 ? pop(i) : 10'h3FF;
                chk($sformatf("inst%0d_byte%0d", i, k), 32'(got),
                    32'({(k == 0), (k == m - 1), ex[k]}));
            end
            if (!nul) exp_seq[i] = exp_seq[i] + 12'd1;
        end
    endtask

    initial begin
        int eops;
        // ---------------- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl0", 32'({out_valid[0], out_sop[0], out_eop[0], crc_en[0], crc_clr[0], in_ready[0], len_err[0]}), 32'd0);
        chk("rst_data0", 32'(out_data[0]), 32'd0);
        chk("rst_seq0", 32'(seq_num[0]), 32'h000);
        chk("rst_seq1", 32'(seq_num[1]), 32'hFFE);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // ---------------- 1-byte TLP, always ready
        pl = '{8'h55};
        send(1, 1'b0);
        frames(1'b0);
        chk("t1_seq0", 32'(seq_num[0]), 32'h001);

        // ---------------- 3-byte TLP, out_ready toggling
        @(posedge clk); #1;
        en_cnt[0] = 0;
        rdy_mode  = 1;
        pl = '{8'hA1, 8'hB2, 8'hC3};
        send(3, 1'b0);
        frames(1'b0);
        @(posedge clk); #1;
        rdy_mode = 0;
        chk("t2_crc_en_cnt", 32'(en_cnt[0]), 32'd5);
        chk("t2_stable0", 32'(stall_err[0]), 32'd0);
        chk("t2_stable1", 32'(stall_err[1]), 32'd0);

        // ---------------- third TLP: u_wrap headers FFE, FFF, 000
        @(posedge clk); #1;
        pl = '{8'h11, 8'h22};
        send(2, 1'b0);
        frames(1'b0);
        chk("t3_seq_wrap", 32'(seq_num[1]), 32'h001);
        chk("t3_seq0", 32'(seq_num[0]), 32'h003);

        // ---------------- rb_full holds off the frame start
        repeat (2) @(posedge clk); #1;
        rb_full  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        in_eop   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4_blocked", 32'({crc_clr[0], in_ready[0], out_valid[0], crc_clr[1]}), 32'd0);
            @(posedge clk); #1;
        end
        rb_full = 1'b0;
        @(negedge clk);
        chk("t4_clr", 32'(crc_clr[0]), 32'd1);
        @(posedge clk); @(negedge clk);
        chk("t4_gap", 32'(out_valid[0]), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("t4_sop", 32'({out_valid[0], out_sop[0]}), 32'b11);
        @(posedge clk); #1;
        pl = '{8'h3C};
        send(1, 1'b0);
        frames(1'b0);

        // ---------------- reset in the middle of a 10-byte TLP
        @(posedge clk); #1;
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        send(4, 1'b0);
        eops = eop_cnt[0];
        in_valid = 1'b1;
        in_data  = 8'h05;
        reset    = 1'b0;
        #1;
        chk("t5_ctl0", 32'({out_valid[0], out_sop[0], out_eop[0], crc_en[0], crc_clr[0], in_ready[0], len_err[0]}), 32'd0);
        chk("t5_data0", 32'({out_data[0], crc_din[0]}), 32'd0);
        chk("t5_seq0", 32'(seq_num[0]), 32'h000);
        chk("t5_seq1", 32'(seq_num[1]), 32'hFFE);
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        reset = 1'b1;
        q0.delete();
        q1.delete();
        exp_seq[0] = 12'h000;
        exp_seq[1] = 12'hFFE;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t5_no_eop", 32'(eop_cnt[0]), 32'(eops));
        @(posedge clk); #1;
        pl = '{8'h99};
        send(1, 1'b0);
        frames(1'b0);

        // ---------------- length limit (MAX_BYTES=4 on u_dut)
        @(posedge clk); #1;
        pl = '{8'hD0, 8'hD1, 8'hD2, 8'hD3};
        send(4, 1'b0);
        frames(1'b0);
        chk("t6_len_ok", 32'(len_err[0]), 32'd0);
        @(posedge clk); #1;
        pl = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4};
        send(5, 1'b0);
        frames(1'b0);
        chk("t6_len_err", 32'(len_err[0]), 32'd1);
        chk("t6_len_wrap", 32'(len_err[1]), 32'd0);
        @(posedge clk); #1;
        pl = '{8'h42};
        send(1, 1'b0);
        frames(1'b0);
        chk("t6_len_sticky", 32'(len_err[0]), 32'd1);

`ifdef LCRC_NULLIFY_EN
        // ---------------- nullified TLP: inverted LCRC, seq_num unchanged
        @(posedge clk); #1;
        pl = '{8'h55};
        send(1, 1'b1);
        frames(1'b1);
        chk("t7_seq0", 32'(seq_num[0]), 32'(exp_seq[0]));
        chk("t7_seq1", 32'(seq_num[1]), 32'(exp_seq[1]));
`endif

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
